// File: rtl/divider32.sv
// Unsigned 32-bit restoring divider, one quotient bit per clock, driven by a start/done/clear handshake.
// Latency: 32 EXEC cycles after the start edge; the result is held in DONE until op_start or op_clear.
module divider32 (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        op_start,
  input  logic        op_clear,
  input  logic [31:0] dividend,
  input  logic [31:0] divisor,
  output logic [31:0] quotient,
  output logic [31:0] remainder,
  output logic        busy,
  output logic        op_done,
  output logic        div_by_zero
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] q_q, q_d;
  logic [32:0] r_q, r_d;
  logic [31:0] d_q, d_d;
  logic [4:0]  cnt_q, cnt_d;
  logic        dbz_q, dbz_d;

  logic [32:0] trial;
  logic [33:0] sum;
  logic        no_borrow;
  logic        accept;
  logic        r_msb_unused;

  // The partial remainder never exceeds 32 significant bits once a step completes.
  assign r_msb_unused = r_q[32];

  assign accept = op_start && !op_clear && (state_q != S_EXEC);

  // Trial subtraction as T + ~{0,D} + 1; the carry out of bit 32 means no borrow.
  always_comb begin
    trial     = {r_q[31:0], q_q[31]};
    sum       = {1'b0, trial} + {1'b0, 1'b1, ~d_q} + 34'd1;
    no_borrow = sum[33];
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      q_q     <= '0;
      r_q     <= '0;
      d_q     <= '0;
      cnt_q   <= '0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      q_q     <= q_d;
      r_q     <= r_d;
      d_q     <= d_d;
      cnt_q   <= cnt_d;
      dbz_q   <= dbz_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (op_clear) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE:  if (op_start) state_d = S_EXEC;
        S_EXEC:  if (cnt_q == 5'd31) state_d = S_DONE;
        S_DONE:  if (op_start) state_d = S_EXEC;
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_comb begin
    q_d   = q_q;
    r_d   = r_q;
    d_d   = d_q;
    cnt_d = cnt_q;
    dbz_d = dbz_q;
    if (op_clear) begin
      q_d   = '0;
      r_d   = '0;
      d_d   = '0;
      cnt_d = '0;
      dbz_d = 1'b0;
    end else if (accept) begin
      q_d   = dividend;
      r_d   = '0;
      d_d   = divisor;
      cnt_d = '0;
      dbz_d = (divisor == 32'd0);
    end else if (state_q == S_EXEC) begin
      if (no_borrow) begin
        r_d = sum[32:0];
        q_d = {q_q[30:0], 1'b1};
      end else begin
        r_d = trial;
        q_d = {q_q[30:0], 1'b0};
      end
      cnt_d = cnt_q + 5'd1;
    end
  end

  always_comb begin
    busy        = (state_q == S_EXEC);
    op_done     = (state_q == S_DONE);
    div_by_zero = (state_q == S_DONE) && dbz_q;
    quotient    = q_q;
    remainder   = r_q[31:0];
  end

endmodule

// File: tb/tb_divider32.sv
// Self-checking bench for divider32: directed cases from the plan plus random operands
// compared against a plain-arithmetic reference.
module tb_divider32;

  logic        clk;
  logic        reset_n;
  logic        op_start;
  logic        op_clear;
  logic [31:0] dividend;
  logic [31:0] divisor;
  logic [31:0] quotient;
  logic [31:0] remainder;
  logic        busy;
  logic        op_done;
  logic        div_by_zero;

  int checks = 0;
  int errors = 0;

  divider32 dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .op_start    (op_start),
    .op_clear    (op_clear),
    .dividend    (dividend),
    .divisor     (divisor),
    .quotient    (quotient),
    .remainder   (remainder),
    .busy        (busy),
    .op_done     (op_done),
    .div_by_zero (div_by_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: ordinary division, with the all-ones/dividend result for a zero divisor.
  function automatic logic [31:0] ref_q(input logic [31:0] a, input logic [31:0] b);
    if (b == 32'd0) return 32'hFFFF_FFFF;
    return a / b;
  endfunction

  function automatic logic [31:0] ref_r(input logic [31:0] a, input logic [31:0] b);
    if (b == 32'd0) return a;
    return a % b;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic start_op(input logic [31:0] a, input logic [31:0] b);
    dividend = a;
    divisor  = b;
    op_start = 1'b1;
    step();
    op_start = 1'b0;
  endtask

  // Returns the number of edges after the start edge until op_done, or -1 on timeout.
  task automatic wait_done(output int n);
    n = -1;
    for (int i = 1; i <= 40; i++) begin
      step();
      if (op_done === 1'b1) begin
        n = i;
        break;
      end
    end
  endtask

  task automatic test_reset();
    reset_n  = 1'b0;
    op_start = 1'b0;
    op_clear = 1'b0;
    dividend = '0;
    divisor  = '0;
    step();
    step();
    checks++; if (quotient !== 32'd0) begin errors++; $display("FAIL reset_quotient: got %h expected 0", quotient); end
    checks++; if (remainder !== 32'd0) begin errors++; $display("FAIL reset_remainder: got %h expected 0", remainder); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
    checks++; if (op_done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", op_done); end
    checks++; if (div_by_zero !== 1'b0) begin errors++; $display("FAIL reset_dbz: got %b expected 0", div_by_zero); end
    reset_n = 1'b1;
    step();
    checks++; if (busy !== 1'b0 || op_done !== 1'b0) begin errors++; $display("FAIL reset_idle: got busy=%b done=%b expected 0/0", busy, op_done); end
  endtask

  task automatic test_basic();
    int n;
    start_op(32'd100, 32'd7);
    checks++; if (busy !== 1'b1 || op_done !== 1'b0) begin errors++; $display("FAIL basic_busy: got busy=%b done=%b expected 1/0", busy, op_done); end
    wait_done(n);
    checks++; if (n != 32) begin errors++; $display("FAIL basic_latency: got %0d edges expected 32", n); end
    checks++; if (quotient !== 32'd14) begin errors++; $display("FAIL basic_q: got %0d expected 14", quotient); end
    checks++; if (remainder !== 32'd2) begin errors++; $display("FAIL basic_r: got %0d expected 2", remainder); end
    checks++; if (div_by_zero !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL basic_flags: got dbz=%b busy=%b expected 0/0", div_by_zero, busy); end
    step();
    checks++; if (op_done !== 1'b1 || quotient !== 32'd14) begin errors++; $display("FAIL basic_hold: got done=%b q=%0d expected 1/14", op_done, quotient); end
  endtask

  task automatic test_full_scale();
    int n;
    start_op(32'hFFFF_FFFF, 32'd1);
    wait_done(n);
    checks++; if (n != 32) begin errors++; $display("FAIL full1_latency: got %0d expected 32", n); end
    checks++; if (quotient !== 32'hFFFF_FFFF || remainder !== 32'd0) begin errors++; $display("FAIL full1_result: got q=%h r=%h expected ffffffff/0", quotient, remainder); end
    start_op(32'hFFFF_FFFF, 32'hFFFF_FFFF);
    wait_done(n);
    checks++; if (quotient !== 32'd1 || remainder !== 32'd0) begin errors++; $display("FAIL full2_result: got q=%h r=%h expected 1/0", quotient, remainder); end
  endtask

  task automatic test_div_zero();
    int n;
    start_op(32'd5, 32'd0);
    checks++; if (div_by_zero !== 1'b0) begin errors++; $display("FAIL dbz_exec: got %b expected 0", div_by_zero); end
    wait_done(n);
    checks++; if (n != 32) begin errors++; $display("FAIL dbz_latency: got %0d expected 32", n); end
    checks++; if (quotient !== 32'hFFFF_FFFF || remainder !== 32'd5) begin errors++; $display("FAIL dbz_result: got q=%h r=%h expected ffffffff/5", quotient, remainder); end
    checks++; if (div_by_zero !== 1'b1) begin errors++; $display("FAIL dbz_flag: got %b expected 1", div_by_zero); end
    start_op(32'd3, 32'd10);
    wait_done(n);
    checks++; if (quotient !== 32'd0 || remainder !== 32'd3) begin errors++; $display("FAIL small_result: got q=%h r=%h expected 0/3", quotient, remainder); end
    checks++; if (div_by_zero !== 1'b0) begin errors++; $display("FAIL small_dbz: got %b expected 0", div_by_zero); end
  endtask

  task automatic test_random();
    int n;
    logic [31:0] a, b;
    for (int k = 0; k < 24; k++) begin
      a = $urandom;
      b = $urandom >> $urandom_range(0, 31);
      if (k % 8 == 7) b = 32'd0;
      start_op(a, b);
      wait_done(n);
      checks++;
      if (n != 32 || quotient !== ref_q(a, b) || remainder !== ref_r(a, b) || div_by_zero !== (b == 32'd0)) begin
        errors++;
        $display("FAIL random_%0d: %h/%h got q=%h r=%h dbz=%b n=%0d expected q=%h r=%h dbz=%b n=32",
                 k, a, b, quotient, remainder, div_by_zero, n, ref_q(a, b), ref_r(a, b), b == 32'd0);
      end
    end
  endtask

  task automatic test_start_ignored();
    int early = 0;
    start_op(32'h1234_5678, 32'h100);
    for (int i = 1; i <= 31; i++) begin
      if (i == 10) begin
        dividend = 32'd9;
        divisor  = 32'd3;
        op_start = 1'b1;
      end
      step();
      op_start = 1'b0;
      if (op_done !== 1'b0 || busy !== 1'b1) early++;
    end
    checks++; if (early != 0) begin errors++; $display("FAIL ignore_early: got %0d bad cycles expected 0", early); end
    step();
    checks++; if (op_done !== 1'b1) begin errors++; $display("FAIL ignore_done: got %b expected 1", op_done); end
    checks++; if (quotient !== 32'h0012_3456 || remainder !== 32'h78) begin errors++; $display("FAIL ignore_result: got q=%h r=%h expected 123456/78", quotient, remainder); end
    step();
    checks++; if (op_done !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL ignore_extra: got done=%b busy=%b expected 1/0", op_done, busy); end
  endtask

  task automatic test_clear();
    int n;
    start_op(32'hDEAD_BEEF, 32'h1234);
    for (int i = 1; i <= 19; i++) step();
    op_clear = 1'b1;
    step();
    op_clear = 1'b0;
    checks++; if (busy !== 1'b0 || op_done !== 1'b0) begin errors++; $display("FAIL clear_state: got busy=%b done=%b expected 0/0", busy, op_done); end
    checks++; if (quotient !== 32'd0 || remainder !== 32'd0) begin errors++; $display("FAIL clear_regs: got q=%h r=%h expected 0/0", quotient, remainder); end
    start_op(32'd50, 32'd6);
    wait_done(n);
    checks++; if (n != 32 || quotient !== 32'd8 || remainder !== 32'd2) begin errors++; $display("FAIL clear_next: got q=%0d r=%0d n=%0d expected 8/2/32", quotient, remainder, n); end
    op_clear = 1'b1;
    op_start = 1'b1;
    step();
    checks++; if (busy !== 1'b0 || op_done !== 1'b0) begin errors++; $display("FAIL clear_start_done: got busy=%b done=%b expected 0/0", busy, op_done); end
    step();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL clear_start_idle: got busy=%b expected 0", busy); end
    op_clear = 1'b0;
    op_start = 1'b0;
    step();
    checks++; if (busy !== 1'b0 || op_done !== 1'b0) begin errors++; $display("FAIL clear_release: got busy=%b done=%b expected 0/0", busy, op_done); end
  endtask

  task automatic test_reset_mid();
    start_op(32'd777, 32'd5);
    for (int i = 0; i < 5; i++) step();
    reset_n = 1'b0;
    step();
    checks++;
    if (quotient !== 32'd0 || remainder !== 32'd0 || busy !== 1'b0 || op_done !== 1'b0 || div_by_zero !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid: got q=%h r=%h busy=%b done=%b dbz=%b expected all 0", quotient, remainder, busy, op_done, div_by_zero);
    end
    reset_n = 1'b1;
    step();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_mid_idle: got busy=%b expected 0", busy); end
  endtask

  task automatic test_back_to_back();
    int pulses[$];
    int wide = 0;
    int bad_val = 0;
    logic prev_done = 1'b0;
    dividend = 32'd1000;
    divisor  = 32'd33;
    op_start = 1'b1;
    step();
    for (int e = 1; e <= 110; e++) begin
      step();
      if (op_done === 1'b1) begin
        pulses.push_back(e);
        if (prev_done) wide++;
        if (quotient !== 32'd30 || remainder !== 32'd10) bad_val++;
      end
      prev_done = op_done;
    end
    op_start = 1'b0;
    checks++; if (pulses.size() != 3) begin errors++; $display("FAIL b2b_count: got %0d pulses expected 3", pulses.size()); end
    checks++; if (wide != 0) begin errors++; $display("FAIL b2b_width: got %0d multi-cycle pulses expected 0", wide); end
    checks++; if (bad_val != 0) begin errors++; $display("FAIL b2b_result: got %0d wrong results expected 0", bad_val); end
    if (pulses.size() == 3) begin
      checks++; if (pulses[0] != 32) begin errors++; $display("FAIL b2b_first: got edge %0d expected 32", pulses[0]); end
      checks++; if (pulses[1] - pulses[0] != 33 || pulses[2] - pulses[1] != 33) begin errors++; $display("FAIL b2b_spacing: got %0d,%0d expected 33,33", pulses[1] - pulses[0], pulses[2] - pulses[1]); end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_full_scale();
    test_div_zero();
    test_random();
    test_start_ignored();
    test_clear();
    test_reset_mid();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
